// File: rtl/store_buffer.sv
// Processor store buffer: a circular FIFO of pending stores that drains to data memory in order
// and forwards the newest matching pending store to a load probe.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [AW-1:0]            dataadr,
  input  logic [DW-1:0]            writedata,
  output logic                     stall,
  output logic                     mem_valid,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  input  logic [AW-1:0]            raddr,
  output logic                     rd_hit,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_align
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             aligned, full, accept, deq;
  logic [PW-1:0]    idx;

  assign aligned = (dataadr[1:0] == 2'b00);
  assign full    = (count_q == CW'(DEPTH));
  // A freed slot from a same-cycle dequeue is not reused until the next cycle.
  assign accept  = memwrite & aligned & ~full;
  assign deq     = (count_q != '0) & mem_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    if (accept) begin
      wr_ptr_d          = wr_ptr_q + PW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (deq) begin
      rd_ptr_d          = rd_ptr_q + PW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    count_d = count_q + CW'(accept) - CW'(deq);
    err_d   = err_q | (memwrite & ~aligned);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset: every read is qualified by valid or count.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[wr_ptr_q] <= dataadr;
      data_q[wr_ptr_q] <= writedata;
    end
  end

  always_comb begin
    stall     = memwrite & aligned & full;
    mem_valid = (count_q != '0);
    mem_addr  = mem_valid ? addr_q[rd_ptr_q] : '0;
    mem_wdata = mem_valid ? data_q[rd_ptr_q] : '0;
    count     = count_q;
    err_align = err_q;
  end

  // Walk oldest to newest so the last match wins, giving the newest matching store.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx][AW-1:2] == raddr[AW-1:2])) begin
        rd_hit  = 1'b1;
        rd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue model predicts count/stall/forwarding, and a
// separate monitor checks every memory handshake against stores queued at acceptance.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr, writedata, raddr;
  logic        mem_ready;
  logic        stall, mem_valid, rd_hit, err_align;
  logic [31:0] mem_addr, mem_wdata, rd_data;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t mdl[$];
  st_t exp_q[$];
  bit  err_m = 1'b0;
  int  checks = 0;
  int  failures = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .stall     (stall),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .raddr     (raddr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .count     (count),
    .err_align (err_align)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs against the model, then advance it.
  task automatic cycle(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] ra);
    bit          aligned, full, hit, acc, dq;
    logic [31:0] fwd;
    @(negedge clk);
    memwrite  = mw;
    dataadr   = adr;
    writedata = wd;
    mem_ready = rdy;
    raddr     = ra;
    #2;
    aligned = (adr[1:0] == 2'b00);
    full    = (mdl.size() == DEPTH);
    hit     = 1'b0;
    fwd     = '0;
    for (int i = mdl.size() - 1; i >= 0; i--) begin
      if (mdl[i].a[31:2] == ra[31:2]) begin
        hit = 1'b1;
        fwd = mdl[i].d;
        break;
      end
    end
    chk("count", 32'(count), 32'(mdl.size()));
    chk("stall", 32'(stall), 32'(mw && aligned && full));
    chk("mem_valid", 32'(mem_valid), 32'(mdl.size() != 0));
    chk("rd_hit", 32'(rd_hit), 32'(hit));
    chk("rd_data", rd_data, fwd);
    chk("err_align", 32'(err_align), 32'(err_m));
    if (mdl.size() == 0) begin
      chk("empty_addr", mem_addr, 32'h0);
      chk("empty_data", mem_wdata, 32'h0);
    end
    if (mw && !aligned) err_m = 1'b1;
    dq  = (mdl.size() != 0) && rdy;
    acc = mw && aligned && !full;
    if (dq) void'(mdl.pop_front());
    if (acc) begin
      mdl.push_back('{a: adr, d: wd});
      exp_q.push_back('{a: adr, d: wd});
    end
  endtask

  // Monitor: every handshake must present the oldest accepted, undrained store.
  initial begin
    st_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset && mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL drain_unexpected actual=%0h expected=none", mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("drain_addr", mem_addr, e.a);
          chk("drain_data", mem_wdata, e.d);
        end
      end
    end
  end

  initial begin
    logic [31:0] adr;
    reset     = 1'b0;
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
    mem_ready = 1'b0;
    raddr     = '0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rd_hit", 32'(rd_hit), 32'h0);
    chk("rst_err", 32'(err_align), 32'h0);
    #11 reset = 1'b1;

    // Single store drained immediately.
    cycle(1'b1, 32'd84, 32'd1, 1'b1, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd84);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);

    // Fill, stall when full, drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 32'(100 + i), 1'b0, 32'd0);
    cycle(1'b1, 32'd16, 32'd200, 1'b0, 32'd0);
    cycle(1'b1, 32'd16, 32'd200, 1'b1, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);

    // Simultaneous accept and dequeue at count 2.
    cycle(1'b1, 32'd32, 32'd11, 1'b0, 32'd0);
    cycle(1'b1, 32'd36, 32'd22, 1'b0, 32'd0);
    cycle(1'b1, 32'd40, 32'd55, 1'b1, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);

    // Forwarding picks the newest matching store.
    cycle(1'b1, 32'd80, 32'd7, 1'b0, 32'd0);
    cycle(1'b1, 32'd80, 32'd9, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd80);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd84);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd80);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd80);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd80);

    // Misaligned store is dropped and flags a sticky error.
    cycle(1'b1, 32'h53, 32'd5, 1'b0, 32'h50);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h50);

    // Asynchronous reset with three stores pending.
    cycle(1'b1, 32'd8, 32'd11, 1'b0, 32'd0);
    cycle(1'b1, 32'd12, 32'd22, 1'b0, 32'd0);
    cycle(1'b1, 32'd16, 32'd33, 1'b0, 32'd8);
    @(negedge clk);
    memwrite = 1'b0;
    raddr    = 32'd8;
    #1 reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_mem_valid", 32'(mem_valid), 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_rd_hit", 32'(rd_hit), 32'h0);
    chk("arst_rd_data", rd_data, 32'h0);
    chk("arst_err", 32'(err_align), 32'h0);
    mdl.delete();
    exp_q.delete();
    err_m = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    cycle(1'b1, 32'd20, 32'd44, 1'b0, 32'd8);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd20);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd8);

    // Randomized traffic over a small address set to exercise forwarding and wrap-around.
    for (int n = 0; n < 500; n++) begin
      adr = 32'($urandom_range(0, 7)) * 32'd4;
      if ($urandom_range(0, 15) == 0 && mdl.size() < DEPTH) adr = adr | 32'($urandom_range(1, 3));
      cycle(1'($urandom_range(0, 2) != 0), adr, $urandom, 1'($urandom_range(0, 2) == 0),
            32'($urandom_range(0, 7)) * 32'd4);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
